// File: rtl/uart_interface_regs.sv
// uart_interface_regs: 8N1 UART with control/TX-data/RX-data register bank.
// Control bit 0 = send, bit 1 = new_rx; hardware set/clear wins over software writes.
module uart_interface_regs #(
   parameter int CLKS_PER_BIT = 1042
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_i,
   input  logic        reg_sel_i,
   input  logic        addr_i,
   input  logic [31:0] entrada_i,
   output logic [31:0] salida_o,
   input  logic        rx,
   output logic        tx
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   logic send, new_rx;
   logic [7:0] tx_data, rx_data;
   logic ctrl_wr, tx_done, rx_done;
   logic unused_bits;
   assign unused_bits = ^entrada_i[31:8];
   assign ctrl_wr = wr_i & ~reg_sel_i;
   // transmitter
   state_t tx_state, tx_next;
   logic [CW-1:0] tx_cnt;
   logic [2:0] tx_bit;
   logic [7:0] tx_shift;
   logic tx_tick;
   assign tx_tick = tx_cnt == '0;
   assign tx_done = tx_state == STOP && tx_tick;
   always_ff @(posedge clk)
      if (rst) tx_state <= IDLE;
      else tx_state <= tx_next;
   always_comb
      tx_next = tx_state == IDLE ? (send ? START : IDLE) :
                !tx_tick ? tx_state :
                tx_state == START ? DATA :
                tx_state == DATA ? (tx_bit == 3'd7 ? STOP : DATA) : IDLE;
   always_comb
      tx = tx_state == START ? 1'b0 : tx_state == DATA ? tx_shift[0] : 1'b1;
   always_ff @(posedge clk)
      if (rst) begin
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
      end else if (tx_state == IDLE) begin
         tx_cnt   <= LAST;
         tx_bit   <= '0;
         tx_shift <= tx_data;
      end else begin
         tx_cnt <= tx_tick ? LAST : tx_cnt - 1'b1;
         if (tx_tick && tx_state == DATA) begin
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + 1'b1;
         end
      end
   // receiver; start detection needs a high-to-low edge so a low line after a framing error is ignored
   state_t rx_state, rx_next;
   logic [1:0] sync;
   logic rx_s, rx_prev, rx_tick;
   logic [CW-1:0] rx_cnt;
   logic [2:0] rx_bit;
   logic [7:0] rx_shift;
   assign rx_s = sync[1];
   assign rx_tick = rx_cnt == '0;
   assign rx_done = rx_state == STOP && rx_tick && rx_s;
   always_ff @(posedge clk)
      if (rst) rx_state <= IDLE;
      else rx_state <= rx_next;
   always_comb
      rx_next = rx_state == IDLE ? (!rx_s && rx_prev ? START : IDLE) :
                !rx_tick ? rx_state :
                rx_state == START ? (rx_s ? IDLE : DATA) :
                rx_state == DATA ? (rx_bit == 3'd7 ? STOP : DATA) : IDLE;
   always_ff @(posedge clk)
      if (rst) begin
         sync     <= 2'b11;
         rx_prev  <= 1'b1;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         sync    <= {sync[0], rx};
         rx_prev <= rx_s;
         if (rx_state == IDLE) begin
            rx_cnt <= HALF;
            rx_bit <= '0;
         end else begin
            rx_cnt <= rx_tick ? LAST : rx_cnt - 1'b1;
            if (rx_tick && rx_state == DATA) begin
               rx_shift <= {rx_s, rx_shift[7:1]};
               rx_bit   <= rx_bit + 1'b1;
            end
         end
      end
   // register bank
   always_ff @(posedge clk)
      if (rst) begin
         send    <= 1'b0;
         new_rx  <= 1'b0;
         tx_data <= '0;
         rx_data <= '0;
      end else begin
         send   <= tx_done ? 1'b0 : ctrl_wr ? entrada_i[0] : send;
         new_rx <= rx_done | (ctrl_wr ? new_rx & entrada_i[1] : new_rx);
         if (wr_i && reg_sel_i && !addr_i) tx_data <= entrada_i[7:0];
         if (rx_done) rx_data <= rx_shift;
      end
   always_comb
      salida_o = !reg_sel_i ? {30'b0, new_rx, send} :
                 addr_i ? {24'b0, rx_data} : {24'b0, tx_data};
endmodule

// File: tb/tb_uart_interface_regs.sv
// tb_uart_interface_regs: randomized bench for uart_interface_regs with a register/frame-level model.
module tb_uart_interface_regs;
   localparam int C = 4;
   logic clk = 1'b0, rst = 1'b1, wr = 1'b0, reg_sel = 1'b0, addr = 1'b0;
   logic [31:0] entrada = '0;
   logic [31:0] salida;
   logic tx_w, rx_drv = 1'b1, loop = 1'b0, rx_line;
   int checks = 0, errors = 0;
   logic m_send = 1'b0, m_new_rx = 1'b0;
   logic [7:0] m_tx_data = '0, m_rx_data = '0;
   assign rx_line = loop ? tx_w : rx_drv;
   uart_interface_regs #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .rst(rst), .wr_i(wr), .reg_sel_i(reg_sel), .addr_i(addr),
      .entrada_i(entrada), .salida_o(salida), .rx(rx_line), .tx(tx_w)
   );
   always #5 clk = ~clk;
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic rd(input logic sel, input logic a, output logic [31:0] d);
      reg_sel = sel;
      addr = a;
      #1;
      d = salida;
   endtask
   task automatic check_regs(input string tag);
      logic [31:0] d;
      rd(1'b0, 1'b0, d);
      chk({tag, "_ctrl"}, d, {30'b0, m_new_rx, m_send});
      rd(1'b1, 1'b0, d);
      chk({tag, "_txdata"}, d, {24'b0, m_tx_data});
      rd(1'b1, 1'b1, d);
      chk({tag, "_rxdata"}, d, {24'b0, m_rx_data});
   endtask
   task automatic wr_reg(input logic sel, input logic a, input logic [31:0] d);
      wr = 1'b1;
      reg_sel = sel;
      addr = a;
      entrada = d;
      tick();
      wr = 1'b0;
      if (!sel) begin
         m_send = d[0];
         m_new_rx = m_new_rx & d[1];
      end else if (!a) m_tx_data = d[7:0];
   endtask
   // Sends m_tx_data and checks every cycle of the 10-bit frame; optionally rewrites tx_data and send=0 mid-frame.
   task automatic tx_frame(input string tag, input logic mid);
      logic [7:0] b;
      logic [31:0] d;
      logic exp;
      wr_reg(1'b0, 1'b0, {30'b0, m_new_rx, 1'b1});
      rd(1'b0, 1'b0, d);
      chk({tag, "_send_set"}, d, {30'b0, m_new_rx, 1'b1});
      b = m_tx_data;
      tick();
      for (int j = 0; j < 10 * C; j++) begin
         exp = (j / C == 0) ? 1'b0 : (j / C == 9) ? 1'b1 : b[j / C - 1];
         chk({tag, "_tx"}, {31'b0, tx_w}, {31'b0, exp});
         if (mid && j == 10) begin
            wr = 1'b1; reg_sel = 1'b1; addr = 1'b0; entrada = $urandom;
         end
         if (mid && j == 11) begin
            wr = 1'b1; reg_sel = 1'b0; addr = 1'b0; entrada = {30'b0, m_new_rx, 1'b0};
         end
         tick();
         if (wr) begin
            wr = 1'b0;
            if (reg_sel) m_tx_data = entrada[7:0];
            else m_send = 1'b0;
         end
      end
      m_send = 1'b0;
      rd(1'b0, 1'b0, d);
      chk({tag, "_send_clr"}, d, {30'b0, m_new_rx, 1'b0});
      chk({tag, "_tx_idle"}, {31'b0, tx_w}, 32'd1);
   endtask
   // Drives one frame on rx; the stop bit is sampled 3 sync/detect cycles + C/2 + 9*C edges after the frame starts.
   task automatic rx_frame(input string tag, input logic [7:0] b, input logic stop, input logic clr);
      logic [31:0] d;
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int j = 0; j < 10 * C; j++) begin
         rx_drv = bits[j / C];
         tick();
      end
      rx_drv = 1'b1;
      for (int j = 10 * C; j < 3 + C / 2 + 9 * C - 1; j++) tick();
      rd(1'b0, 1'b0, d);
      chk({tag, "_pre_sample"}, d, {30'b0, m_new_rx, m_send});
      if (clr) begin
         wr = 1'b1; reg_sel = 1'b0; entrada = '0;
      end
      tick();
      wr = 1'b0;
      if (clr) begin
         m_send = 1'b0;
         m_new_rx = 1'b0;
      end
      if (stop) begin
         m_new_rx = 1'b1;
         m_rx_data = b;
      end
      check_regs(tag);
      repeat (3) tick();
   endtask
   initial begin
      logic [31:0] d;
      logic [7:0] b;
      repeat (3) tick();
      check_regs("reset");
      chk("reset_tx", {31'b0, tx_w}, 32'd1);
      rst = 1'b0;
      tick();
      wr_reg(1'b1, 1'b0, 32'h0000_0155);
      rd(1'b1, 1'b0, d);
      chk("txdata_trunc", d, 32'h55);
      tx_frame("tx55", 1'b0);
      rx_frame("rx3c", 8'h3C, 1'b1, 1'b0);
      wr_reg(1'b0, 1'b0, 32'h0);
      check_regs("clr_new_rx");
      rx_frame("rx_vs_clr", 8'($urandom), 1'b1, 1'b1);
      wr_reg(1'b0, 1'b0, 32'h0);
      rx_frame("rx_framing", 8'hA5, 1'b0, 1'b0);
      rx_drv = 1'b0;
      tick();
      rx_drv = 1'b1;
      repeat (20) tick();
      check_regs("glitch");
      wr_reg(1'b1, 1'b1, $urandom);
      check_regs("rxdata_ro");
      for (int i = 0; i < 4; i++) begin
         wr_reg(1'b1, 1'b0, $urandom);
         tx_frame("tx_rand", 1'($urandom));
         if ($urandom_range(0, 1) == 0) wr_reg(1'b0, 1'b0, 32'h0);
         rx_frame("rx_rand", 8'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
      end
      wr_reg(1'b0, 1'b0, 32'h0);
      loop = 1'b1;
      wr_reg(1'b1, 1'b0, 32'h7E);
      tx_frame("loop", 1'b0);
      repeat (3) tick();
      m_rx_data = 8'h7E;
      m_new_rx = 1'b1;
      check_regs("loop");
      loop = 1'b0;
      repeat (3) tick();
      b = 8'($urandom);
      wr_reg(1'b1, 1'b0, {24'b0, b});
      wr_reg(1'b0, 1'b0, 32'h3);
      repeat (1 + 4 * C + 1) tick();
      chk("pre_rst_bit3", {31'b0, tx_w}, {31'b0, b[3]});
      rst = 1'b1;
      tick();
      chk("rst_tx", {31'b0, tx_w}, 32'd1);
      m_send = 1'b0; m_new_rx = 1'b0; m_tx_data = '0; m_rx_data = '0;
      check_regs("rst_mid");
      rst = 1'b0;
      tick();
      wr_reg(1'b1, 1'b0, $urandom);
      tx_frame("post_rst", 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_interface_regs.md
Name: uart_interface_regs

Overview:
- UART peripheral with a memory-mapped register bank: one control register and two data registers (TX data, RX data).
- Sits directly downstream of the test/control FSM, which drives wr_i, reg_sel_i, addr_i and entrada_i and reads back salida_o.
- Contains an 8N1 transmitter and receiver on the physical tx/rx pins.
- Control bit 0 (send) and bit 1 (new_rx) form the handshake between the FSM and the serial engines.

Parameters:
- CLKS_PER_BIT, 1042, clock cycles per UART bit (10 MHz / 9600 baud); must be at least 4.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- wr_i  in  1  write enable for the selected register; sampled on posedge clk.
- reg_sel_i  in  1  0 = control register, 1 = data bank.
- addr_i  in  1  data bank address (0 = TX data, 1 = RX data); ignored when reg_sel_i = 0.
- entrada_i  in  32  write data.
- salida_o  out  32  read data of the selected register; combinational from the registers.
- rx  in  1  serial input; asynchronous to clk.
- tx  out  1  serial output; idles high.

Behaviour:
- Reset: control, TX data and RX data registers = 0; TX FSM = IDLE; RX FSM = IDLE; tx = 1; both synchronizer flops = 1.
- Read mux:
  - reg_sel_i = 0: salida_o = {30'b0, new_rx, send}.
  - reg_sel_i = 1, addr_i = 0: salida_o = {24'b0, tx_data[7:0]}.
  - reg_sel_i = 1, addr_i = 1: salida_o = {24'b0, rx_data[7:0]}.
- TX data write: wr_i & reg_sel_i & !addr_i loads entrada_i[7:0]; upper bits are discarded.
- RX data register: writes are ignored; hardware is the only writer.
- Control write (wr_i & !reg_sel_i):
  - send <= entrada_i[0].
  - new_rx <= new_rx & entrada_i[1]; software can only clear it.
  - Writing send = 0 while a frame is in progress does not abort the frame.
- Hardware priority, same cycle as a control write:
  - RX frame completion sets new_rx = 1; the set wins over a software clear.
  - TX stop-bit completion clears send = 0; the clear wins over a software write of 1.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when send = 1. The byte is latched from tx_data on this transition.
  - START: tx = 0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: tx = 1 for CLKS_PER_BIT cycles, then send <= 0 and return to IDLE.
  - Latency: control write at edge N -> send = 1 after N; START begins at N+1 (tx low from edge N+1); send clears at N+1+10*CLKS_PER_BIT.
  - tx_data writes during a frame do not affect the frame in flight.
- RX front end: rx passes through a 2-flop synchronizer; the FSM uses the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized falling edge (level 0).
  - START: at CLKS_PER_BIT/2, re-sample. If 1, treat as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample 8 bits at bit centres (every CLKS_PER_BIT), LSB first.
  - STOP: sample at centre. If 1, rx_data <= byte and new_rx <= 1. If 0 (framing error), discard the byte, leave new_rx unchanged, return to IDLE.
  - After STOP, wait for the line to be high before accepting the next start bit.
  - Overrun: a valid frame while new_rx = 1 overwrites rx_data; new_rx stays 1.
- TX and RX are fully independent; a loopback (tx -> rx) must work.
- Reset mid-frame: both FSMs abort immediately, tx = 1 on the next cycle, all registers cleared.
- Bit counters use $clog2(CLKS_PER_BIT) bits; the baud counter reloads at CLKS_PER_BIT-1.

Test Plan (CLKS_PER_BIT = 4):
- Write TX data = 32'h0000_0155, then write control = 1 -> tx waveform 0,1,0,1,0,1,0,1,0,1 (4 cycles each); salida_o (control) = 1 during the frame and 0 exactly 40 cycles after the start bit begins.
- Drive rx with frame 0x3C (start, LSB first, stop = 1) -> new_rx = 1 one cycle after the stop-bit sample; RX data read = 32'h0000_003C; control read = 32'h2.
- Write control = 0 with new_rx set -> control reads 0; receive a frame whose stop-bit-sample cycle coincides with a control write of 0 -> new_rx = 1.
- Drive rx with frame 0xA5 with stop bit = 0 -> new_rx stays 0 and RX data unchanged; also drive a 1-cycle low glitch -> no reception.
- Loopback tx -> rx, send 0x7E -> RX data = 0x7E, new_rx = 1, send = 0.
- Assert rst mid-TX (bit 3) -> tx = 1 the next cycle; all registers read 0; a subsequent send transmits normally.
